// File: rtl/mux_arb_fifo_2x1_if.sv
// Handshake bundle for mux_arb_fifo_2x1: two push lanes in, one valid/ready word out.
// master drives the lanes and ready_out; slave is the arbiter/FIFO block.
interface mux_arb_fifo_2x1_if #(
    parameter int unsigned W = 2
);
    logic [W-1:0] in_0;
    logic         push_0;
    logic         full_0;
    logic [W-1:0] in_1;
    logic         push_1;
    logic         full_1;
    logic         ready_out;
    logic         valid_out;
    logic [W-1:0] data_out_2;
    logic         selector;

    modport master (
        output in_0, push_0, in_1, push_1, ready_out,
        input  full_0, full_1, valid_out, data_out_2, selector
    );

    modport slave (
        input  in_0, push_0, in_1, push_1, ready_out,
        output full_0, full_1, valid_out, data_out_2, selector
    );
endinterface

// File: rtl/mux_arb_fifo_2x1.sv
// Two-lane FIFO buffer plus arbiter feeding a registered valid/ready output word.
// Define MUX_ARB_RR_EN for round-robin tie-breaking; default is fixed priority (lane 0).
module mux_arb_fifo_2x1 #(
    parameter int unsigned W     = 2,
    parameter int unsigned DEPTH = 4
) (
    input logic               clk,
    input logic               reset,
    mux_arb_fifo_2x1_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state, state_next;
    logic [W-1:0]  mem_0 [DEPTH];
    logic [W-1:0]  mem_1 [DEPTH];
    logic [PW-1:0] wr_ptr_0, rd_ptr_0, wr_ptr_1, rd_ptr_1;
    logic [W-1:0]  data_reg;
    logic          sel_reg;
    logic          last_grant;

    logic empty_0, empty_1, full_0, full_1;
    logic wr_en_0, wr_en_1;
    logic valid, load, grant, tie_grant;
    logic pop_0, pop_1;

    assign empty_0 = (wr_ptr_0 == rd_ptr_0);
    assign empty_1 = (wr_ptr_1 == rd_ptr_1);
    assign full_0  = (wr_ptr_0[PW-1] != rd_ptr_0[PW-1]) && (wr_ptr_0[AW-1:0] == rd_ptr_0[AW-1:0]);
    assign full_1  = (wr_ptr_1[PW-1] != rd_ptr_1[PW-1]) && (wr_ptr_1[AW-1:0] == rd_ptr_1[AW-1:0]);

    // Full is judged on the registered pointers, so a push into a full lane is
    // dropped even when that lane is popped in the same cycle.
    assign wr_en_0 = bus.push_0 && !full_0;
    assign wr_en_1 = bus.push_1 && !full_1;

    assign valid = (state == SEND);
    assign load  = (!valid || bus.ready_out) && (!empty_0 || !empty_1);

`ifdef MUX_ARB_RR_EN
    assign tie_grant = ~last_grant;
`else
    // last_grant is tracked in both modes; fixed priority masks it off.
    assign tie_grant = last_grant & 1'b0;
`endif

    always_comb begin
        grant = 1'b0;
        if (empty_0)
            grant = 1'b1;
        else if (!empty_1)
            grant = tie_grant;
    end

    assign pop_0 = load && !grant;
    assign pop_1 = load && grant;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (load) state_next = SEND;
            SEND: if (load) state_next = SEND;
                  else if (bus.ready_out) state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (wr_en_0) mem_0[wr_ptr_0[AW-1:0]] <= bus.in_0;
            if (wr_en_1) mem_1[wr_ptr_1[AW-1:0]] <= bus.in_1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr_0   <= '0;
            rd_ptr_0   <= '0;
            wr_ptr_1   <= '0;
            rd_ptr_1   <= '0;
            data_reg   <= '0;
            sel_reg    <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state <= state_next;
            if (wr_en_0) wr_ptr_0 <= wr_ptr_0 + PW'(1);
            if (wr_en_1) wr_ptr_1 <= wr_ptr_1 + PW'(1);
            if (pop_0)   rd_ptr_0 <= rd_ptr_0 + PW'(1);
            if (pop_1)   rd_ptr_1 <= rd_ptr_1 + PW'(1);
            if (load) begin
                data_reg   <= grant ? mem_1[rd_ptr_1[AW-1:0]] : mem_0[rd_ptr_0[AW-1:0]];
                sel_reg    <= grant;
                last_grant <= grant;
            end
        end
    end

    assign bus.full_0     = full_0;
    assign bus.full_1     = full_1;
    assign bus.valid_out  = valid;
    assign bus.data_out_2 = data_reg;
    assign bus.selector   = sel_reg;
endmodule

// File: tb/tb_mux_arb_fifo_2x1.sv
// Directed bench for mux_arb_fifo_2x1: reset, single lane, overflow, backpressure,
// tie arbitration (expectations follow MUX_ARB_RR_EN) and reset mid-stream.
module tb_mux_arb_fifo_2x1;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    mux_arb_fifo_2x1_if #(.W(2)) bus ();

    mux_arb_fifo_2x1 #(.W(2), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] d, input logic s);
        chk({tag, ".valid"}, {3'b0, bus.valid_out}, {3'b0, v});
        if (v) begin
            chk({tag, ".data"}, {2'b0, bus.data_out_2}, {2'b0, d});
            chk({tag, ".sel"},  {3'b0, bus.selector},   {3'b0, s});
        end
    endtask

    logic [1:0] tie_d [8];
    logic       tie_s [8];

    initial begin
`ifdef MUX_ARB_RR_EN
        tie_d = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b10, 2'b01, 2'b11, 2'b00};
        tie_s = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        tie_d = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00};
        tie_s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
        // Reset held two cycles with a push pending
        reset = 1'b1;
        bus.in_0 = 2'b11; bus.push_0 = 1'b1;
        bus.in_1 = 2'b00; bus.push_1 = 1'b0;
        bus.ready_out = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst.valid", {3'b0, bus.valid_out}, 4'h0);
            chk("rst.data",  {2'b0, bus.data_out_2}, 4'h0);
            chk("rst.sel",   {3'b0, bus.selector}, 4'h0);
            chk("rst.full0", {3'b0, bus.full_0}, 4'h0);
        end
        reset = 1'b0; bus.push_0 = 1'b0;
        tick(); chk_out("rst.after1", 1'b0, 2'b00, 1'b0);
        tick(); chk_out("rst.after2", 1'b0, 2'b00, 1'b0);

        // Single lane, ready held high
        bus.push_0 = 1'b1; bus.in_0 = 2'b01;
        tick(); chk_out("lane0.lat", 1'b0, 2'b00, 1'b0);
        bus.in_0 = 2'b10;
        tick(); chk_out("lane0.w0", 1'b1, 2'b01, 1'b0);
        bus.in_0 = 2'b11;
        tick(); chk_out("lane0.w1", 1'b1, 2'b10, 1'b0);
        bus.push_0 = 1'b0;
        tick(); chk_out("lane0.w2", 1'b1, 2'b11, 1'b0);
        tick(); chk_out("lane0.idle", 1'b0, 2'b00, 1'b0);

        // Park 10 from lane 0 in the output register, then overfill lane 1
        bus.ready_out = 1'b0;
        bus.push_0 = 1'b1; bus.in_0 = 2'b10;
        tick(); chk_out("ovf.pre", 1'b0, 2'b00, 1'b0);
        bus.push_0 = 1'b0;
        bus.push_1 = 1'b1; bus.in_1 = 2'b00;
        tick(); chk_out("ovf.park", 1'b1, 2'b10, 1'b0);
        bus.in_1 = 2'b01; tick();
        bus.in_1 = 2'b10; tick();
        chk("ovf.full1_at3", {3'b0, bus.full_1}, 4'h0);
        bus.in_1 = 2'b11; tick();
        chk("ovf.full1_at4", {3'b0, bus.full_1}, 4'h1);
        bus.in_1 = 2'b01; tick();
        chk("ovf.full1_drop", {3'b0, bus.full_1}, 4'h1);
        bus.push_1 = 1'b0;

        // Backpressure: output must hold for three stalled cycles
        for (int i = 0; i < 3; i++) begin
            tick(); chk_out("bp.hold", 1'b1, 2'b10, 1'b0);
        end
        bus.ready_out = 1'b1;
        tick(); chk_out("drain.0", 1'b1, 2'b00, 1'b1);
        chk("drain.full1", {3'b0, bus.full_1}, 4'h0);
        tick(); chk_out("drain.1", 1'b1, 2'b01, 1'b1);
        tick(); chk_out("drain.2", 1'b1, 2'b10, 1'b1);
        tick(); chk_out("drain.3", 1'b1, 2'b11, 1'b1);
        tick(); chk_out("drain.end", 1'b0, 2'b00, 1'b0);

        // Tie: both lanes backlogged; first word loads while ready_out is low
        bus.ready_out = 1'b0;
        bus.push_0 = 1'b1; bus.push_1 = 1'b1;
        bus.in_0 = 2'b00; bus.in_1 = 2'b11; tick();
        bus.in_0 = 2'b01; bus.in_1 = 2'b10; tick();
        bus.in_0 = 2'b10; bus.in_1 = 2'b01; tick();
        bus.in_0 = 2'b11; bus.in_1 = 2'b00; tick();
        bus.push_0 = 1'b0; bus.push_1 = 1'b0;
        chk("tie.full1", {3'b0, bus.full_1}, 4'h1);
        chk_out("tie.0", 1'b1, tie_d[0], tie_s[0]);
        bus.ready_out = 1'b1;
        for (int i = 1; i < 8; i++) begin
            tick(); chk_out($sformatf("tie.%0d", i), 1'b1, tie_d[i], tie_s[i]);
        end
        tick(); chk_out("tie.end", 1'b0, 2'b00, 1'b0);

        // Reset mid-stream with words buffered and one in the output register
        bus.ready_out = 1'b0;
        bus.push_0 = 1'b1; bus.push_1 = 1'b1;
        bus.in_0 = 2'b01; bus.in_1 = 2'b10; tick();
        bus.in_0 = 2'b10; bus.in_1 = 2'b01; tick();
        bus.push_1 = 1'b0; bus.in_0 = 2'b11; tick();
        chk_out("mid.pre", 1'b1, 2'b01, 1'b0);
        reset = 1'b1; bus.push_1 = 1'b1;
        tick();
        chk("mid.valid", {3'b0, bus.valid_out}, 4'h0);
        chk("mid.data",  {2'b0, bus.data_out_2}, 4'h0);
        chk("mid.full0", {3'b0, bus.full_0}, 4'h0);
        chk("mid.full1", {3'b0, bus.full_1}, 4'h0);
        reset = 1'b0; bus.push_0 = 1'b0; bus.push_1 = 1'b0; bus.ready_out = 1'b1;
        tick(); chk_out("mid.gone1", 1'b0, 2'b00, 1'b0);
        tick(); chk_out("mid.gone2", 1'b0, 2'b00, 1'b0);
        bus.push_1 = 1'b1; bus.in_1 = 2'b11;
        tick(); chk_out("mid.lat", 1'b0, 2'b00, 1'b0);
        bus.push_1 = 1'b0;
        tick(); chk_out("mid.fresh", 1'b1, 2'b11, 1'b1);
        tick(); chk_out("mid.end", 1'b0, 2'b00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
